// File: rtl/code_pkg.sv
// Shared types and code-conversion helpers for the counter bank and its
// receive-side step monitor.
package code_pkg;

  localparam int CNT_W = 3;
  localparam int OH_W  = 8;

  typedef enum logic {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] gray_to_bin(input logic [CNT_W-1:0] g);
    logic [CNT_W-1:0] b;
    logic             acc;
    acc = 1'b0;
    b   = '0;
    for (int i = CNT_W - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

  // Index of the lowest set bit; an all-zero vector decodes to 0.
  function automatic logic [CNT_W-1:0] onehot_to_bin(input logic [OH_W-1:0] oh);
    logic [CNT_W-1:0] idx;
    idx = '0;
    for (int i = OH_W - 1; i >= 0; i--) begin
      if (oh[i]) begin
        idx = CNT_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [CNT_W:0] onehot_popcount(input logic [OH_W-1:0] oh);
    logic [CNT_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < OH_W; i++) begin
      cnt = cnt + (CNT_W + 1)'(oh[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/code_step_monitor_sync_bus.sv
// Multi-flop synchroniser for a bus of quasi-static inputs.
module sync_bus #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/code_step_monitor.sv
// Receive-side checker: decodes synchronised Gray and one-hot counts,
// cross-checks them and verifies every count change is a legal +/-1 step.
module code_step_monitor #(
  parameter  int WIDTH       = 3,
  parameter  int SYNC_STAGES = 2,
  parameter  int SETTLE      = 2,
  localparam int OH_W        = 1 << WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dir,
  input  logic [WIDTH-1:0] grey_in,
  input  logic [OH_W-1:0]  onehot_in,
  output logic [WIDTH-1:0] grey_bin,
  output logic [WIDTH-1:0] onehot_bin,
  output logic             locked,
  output logic             step_pulse,
  output logic             err_onehot,
  output logic             err_mismatch,
  output logic             err_step,
  output logic [7:0]       err_count
);

  import code_pkg::*;

  localparam int BUS_W    = 1 + WIDTH + OH_W;
  localparam int FILL_W   = $clog2(SYNC_STAGES + 2);
  localparam int SETTLE_W = $clog2(SETTLE + 1);
  localparam logic [FILL_W-1:0]   FILL_DONE  = FILL_W'(SYNC_STAGES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE);

  logic [BUS_W-1:0] sync_out;
  logic             dir_sync;
  logic [WIDTH-1:0] grey_sync;
  logic [OH_W-1:0]  onehot_sync;

  sync_bus #(
    .W     (BUS_W),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i ({dir, grey_in, onehot_in}),
    .data_o (sync_out)
  );

  assign dir_sync    = sync_out[BUS_W-1];
  assign grey_sync   = sync_out[OH_W +: WIDTH];
  assign onehot_sync = sync_out[OH_W-1:0];

  logic [WIDTH-1:0]  grey_bin_d, grey_bin_q;
  logic [WIDTH-1:0]  onehot_bin_d, onehot_bin_q;
  logic              err_onehot_d, err_onehot_q;
  logic              dir_q;
  logic [FILL_W-1:0] fill_d, fill_q;
  logic [WIDTH:0]    oh_pop;
  logic              gray_acc;

  always_comb begin
    gray_acc     = 1'b0;
    grey_bin_d   = '0;
    onehot_bin_d = '0;
    oh_pop       = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      gray_acc      = gray_acc ^ grey_sync[i];
      grey_bin_d[i] = gray_acc;
    end
    for (int i = OH_W - 1; i >= 0; i--) begin
      if (onehot_sync[i]) begin
        onehot_bin_d = WIDTH'(i);
      end else begin
        onehot_bin_d = onehot_bin_d;
      end
      oh_pop = oh_pop + (WIDTH + 1)'(onehot_sync[i]);
    end
    err_onehot_d = (oh_pop != (WIDTH + 1)'(1));
    if (fill_q == FILL_DONE) begin
      fill_d = fill_q;
    end else begin
      fill_d = fill_q + FILL_W'(1);
    end
  end

  // Decode registers; fill_q marks when they first carry real input data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grey_bin_q   <= '0;
      onehot_bin_q <= '0;
      err_onehot_q <= 1'b0;
      dir_q        <= 1'b0;
      fill_q       <= '0;
    end else begin
      grey_bin_q   <= grey_bin_d;
      onehot_bin_q <= onehot_bin_d;
      err_onehot_q <= err_onehot_d;
      dir_q        <= dir_sync;
      fill_q       <= fill_d;
    end
  end

  state_t              state_d, state_q;
  logic [WIDTH-1:0]    prev_d, prev_q;
  logic [WIDTH-1:0]    expected;
  logic [SETTLE_W-1:0] settle_d, settle_q;
  logic                consistent, fault;
  logic                step_d, step_q;
  logic                err_step_d, err_step_q;
  logic                err_mismatch_d, err_mismatch_q;
  logic                locked_q;
  logic [7:0]          err_count_d, err_count_q;

  always_comb begin
    state_d        = state_q;
    prev_d         = prev_q;
    step_d         = 1'b0;
    err_step_d     = 1'b0;
    err_mismatch_d = 1'b0;
    consistent     = (fill_q == FILL_DONE) && !err_onehot_q && (grey_bin_q == onehot_bin_q);
    if (consistent || (fill_q != FILL_DONE)) begin
      settle_d = '0;
    end else if (settle_q == SETTLE_MAX) begin
      settle_d = settle_q;
    end else begin
      settle_d = settle_q + SETTLE_W'(1);
    end
    fault    = (settle_d == SETTLE_MAX);
    expected = dir_q ? (prev_q + WIDTH'(1)) : (prev_q - WIDTH'(1));

    case (state_q)
      ACQ: begin
        if (consistent) begin
          prev_d  = grey_bin_q;
          state_d = TRACK;
        end else begin
          state_d = ACQ;
        end
      end
      TRACK: begin
        // A persistent disagreement outranks any step seen in the same cycle.
        if (fault) begin
          err_mismatch_d = 1'b1;
          state_d        = ACQ;
        end else if (consistent && (grey_bin_q != prev_q)) begin
          if (grey_bin_q == expected) begin
            step_d = 1'b1;
          end else begin
            err_step_d = 1'b1;
          end
          prev_d = grey_bin_q;
        end else begin
          state_d = TRACK;
        end
      end
      default: begin
        state_d = ACQ;
      end
    endcase

    if ((err_step_d || err_mismatch_d) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Monitor state, event pulses and the saturating error counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ACQ;
      prev_q         <= '0;
      settle_q       <= '0;
      step_q         <= 1'b0;
      err_step_q     <= 1'b0;
      err_mismatch_q <= 1'b0;
      locked_q       <= 1'b0;
      err_count_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      settle_q       <= settle_d;
      step_q         <= step_d;
      err_step_q     <= err_step_d;
      err_mismatch_q <= err_mismatch_d;
      locked_q       <= (state_q == TRACK);
      err_count_q    <= err_count_d;
    end
  end

  assign grey_bin     = grey_bin_q;
  assign onehot_bin   = onehot_bin_q;
  assign err_onehot   = err_onehot_q;
  assign locked       = locked_q;
  assign step_pulse   = step_q;
  assign err_step     = err_step_q;
  assign err_mismatch = err_mismatch_q;
  assign err_count    = err_count_q;

endmodule
